// File: rtl/ex_mem.sv
// EX/MEM pipeline register with bubble/hold control and madd/msub partial-product buffer.
// Optional synchronous flush port enabled by defining EX_MEM_FLUSH_EN.
module ex_mem (
    input  logic        clk,
    input  logic        rst,
`ifdef EX_MEM_FLUSH_EN
    input  logic        flush,
`endif
    input  logic [5:0]  stall,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic        ex_whilo,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [63:0] hilo_i,
    input  logic [1:0]  cnt_i,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic [63:0] hilo_o,
    output logic [1:0]  cnt_o
);

    logic clear_all;
`ifdef EX_MEM_FLUSH_EN
    assign clear_all = rst | flush;
`else
    assign clear_all = rst;
`endif

    always_ff @(posedge clk) begin
        if (clear_all) begin
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_whilo <= 1'b0;
            mem_hi    <= '0;
            mem_lo    <= '0;
            hilo_o    <= '0;
            cnt_o     <= '0;
        end else if (!stall[3]) begin
            // Advance; an illegal stall[4]-only vector also lands here.
            mem_wd    <= ex_wd;
            mem_wreg  <= ex_wreg;
            mem_wdata <= ex_wdata;
            mem_whilo <= ex_whilo;
            mem_hi    <= ex_hi;
            mem_lo    <= ex_lo;
            hilo_o    <= '0;
            cnt_o     <= '0;
        end else if (!stall[4]) begin
            // Bubble into MEM while EX self-stalls; keep the partial product alive.
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_whilo <= 1'b0;
            mem_hi    <= '0;
            mem_lo    <= '0;
            hilo_o    <= hilo_i;
            cnt_o     <= cnt_i;
        end
    end

endmodule
